// File: rtl/e1of4_pkg.sv
// Shared types and helpers for the e1of4 stream transmitter.
// Holds the handshake FSM state encoding and the 2-bit to 1-of-4 rail encoder.
package e1of4_pkg;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_DATA    = 2'd1,
    ST_NEUTRAL = 2'd2
  } state_t;

  // Value v drives rail v of the digit; exactly one rail is high.
  function automatic logic [3:0] enc_1of4(input logic [1:0] v);
    logic [3:0] r;
    r = 4'b0001 << v;
    return r;
  endfunction

endpackage

// File: rtl/e1of4_token_fifo.sv
// Small token FIFO with combinational head so the transmitter can pop and
// load the rails on the same edge.
module e1of4_token_fifo #(
  parameter int DW    = 8,
  parameter int DEPTH = 4
) (
  input  logic          CLK,
  input  logic          RESET,
  input  logic          push,
  input  logic [DW-1:0] push_data,
  input  logic          pop,
  output logic [DW-1:0] head,
  output logic          full,
  output logic          empty
);

  localparam int AW = $clog2(DEPTH);

  logic [DW-1:0] mem_q [DEPTH];
  logic [AW:0]   wr_ptr_q, wr_ptr_d;
  logic [AW:0]   rd_ptr_q, rd_ptr_d;
  logic          do_push;
  logic          do_pop;

  // Extra pointer bit distinguishes full from empty when the indices match.
  assign empty   = (wr_ptr_q == rd_ptr_q);
  assign full    = (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]) && (wr_ptr_q[AW] != rd_ptr_q[AW]);
  assign do_push = push && !full;
  assign do_pop  = pop && !empty;
  assign head    = mem_q[rd_ptr_q[AW-1:0]];

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    if (do_push) wr_ptr_d = wr_ptr_q + 1'b1;
    if (do_pop)  rd_ptr_d = rd_ptr_q + 1'b1;
  end

  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
    end
  end

  always_ff @(posedge CLK) begin
    if (do_push) mem_q[wr_ptr_q[AW-1:0]] <= push_data;
  end

endmodule

// File: rtl/e1of4_stream_tx.sv
// Streams binary tokens out as delay-insensitive e1of4 digits using a
// four-phase return-to-zero handshake against an asynchronous Txe enable.
module e1of4_stream_tx
  import e1of4_pkg::*;
#(
  parameter int DW          = 8,
  parameter int DEPTH       = 4,
  parameter int SYNC_STAGES = 2,
  parameter int TIMEOUT     = 1023
) (
  input  logic                  CLK,
  input  logic                  RESET,
  input  logic [DW-1:0]         in_data,
  input  logic                  in_valid,
  output logic                  in_ready,
  output logic [4*(DW/2)-1:0]   Tx,
  input  logic                  Txe,
  output logic [15:0]           tx_count,
  output logic                  busy,
  output logic                  timeout_err
);

  localparam int ND = DW / 2;
  localparam int CW = $clog2(TIMEOUT + 1);
  localparam logic [CW-1:0] TMO = CW'(TIMEOUT);

  logic [SYNC_STAGES-1:0] sync_q, sync_d;
  logic                   txe_s;

  state_t                 state_q, state_d;
  logic [4*ND-1:0]        tx_q, tx_d;
  logic [15:0]            count_q, count_d;
  logic [CW-1:0]          tmr_q, tmr_d;
  logic                   err_q, err_d;

  logic [DW-1:0]          fifo_head;
  logic                   fifo_full;
  logic                   fifo_empty;
  logic                   fifo_pop;
  logic [4*ND-1:0]        enc_rails;

  assign sync_d = {sync_q[SYNC_STAGES-2:0], Txe};
  assign txe_s  = sync_q[SYNC_STAGES-1];

  // A full FIFO refuses the offer even if the FSM pops on the same edge.
  assign in_ready = !fifo_full;

  e1of4_token_fifo #(
    .DW    (DW),
    .DEPTH (DEPTH)
  ) u_fifo (
    .CLK       (CLK),
    .RESET     (RESET),
    .push      (in_valid && in_ready),
    .push_data (in_data),
    .pop       (fifo_pop),
    .head      (fifo_head),
    .full      (fifo_full),
    .empty     (fifo_empty)
  );

  for (genvar gi = 0; gi < ND; gi++) begin : g_enc
    assign enc_rails[4*gi +: 4] = enc_1of4(fifo_head[2*gi +: 2]);
  end

  always_comb begin
    state_d  = state_q;
    tx_d     = tx_q;
    count_d  = count_q;
    fifo_pop = 1'b0;
    unique case (state_q)
      ST_IDLE: begin
        if (!fifo_empty && txe_s) begin
          state_d  = ST_DATA;
          tx_d     = enc_rails;
          fifo_pop = 1'b1;
        end
      end
      ST_DATA: begin
        if (!txe_s) begin
          state_d = ST_NEUTRAL;
          tx_d    = '0;
        end
      end
      ST_NEUTRAL: begin
        if (txe_s) begin
          state_d = ST_IDLE;
          count_d = count_q + 16'd1;
        end
      end
      default: begin
        state_d = ST_IDLE;
        tx_d    = '0;
      end
    endcase
  end

  // Timer holds the number of cycles the current wait state has been occupied,
  // counting the cycle of entry as 1; it saturates once the limit is hit.
  always_comb begin
    tmr_d = tmr_q;
    if (state_d != state_q) begin
      tmr_d = (state_d == ST_IDLE) ? '0 : CW'(1);
    end else if (state_q != ST_IDLE && tmr_q != TMO) begin
      tmr_d = tmr_q + CW'(1);
    end
    err_d = err_q || (tmr_d == TMO);
  end

  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET) begin
      sync_q  <= '0;
      state_q <= ST_IDLE;
      tx_q    <= '0;
      count_q <= '0;
      tmr_q   <= '0;
      err_q   <= 1'b0;
    end else begin
      sync_q  <= sync_d;
      state_q <= state_d;
      tx_q    <= tx_d;
      count_q <= count_d;
      tmr_q   <= tmr_d;
      err_q   <= err_d;
    end
  end

  assign Tx          = tx_q;
  assign tx_count    = count_q;
  assign timeout_err = err_q;
  assign busy        = !fifo_empty || (state_q != ST_IDLE);

endmodule

// File: doc/e1of4_stream_tx.md
E1OF4_STREAM_TX -- requirements
Module: e1of4_stream_tx

Interface
REQ-001 SHALL have parameter DW, default 8, binary token width (even, >=2); digit count ND=DW/2.
REQ-002 SHALL have parameter DEPTH, default 4, token FIFO depth (power of 2, >=2).
REQ-003 SHALL have parameter SYNC_STAGES, default 2, Txe synchroniser flops (>=2).
REQ-004 SHALL have parameter TIMEOUT, default 1023, handshake-phase cycle limit (>=1).
REQ-005 SHALL have ports, one clock, reset asynchronous and active-high: CLK input 1 clock; RESET input 1 async active-high reset.
REQ-006 SHALL have in_data input DW binary token; in_valid input 1 token offered; in_ready output 1 token accepted when in_valid&in_ready at CLK rise.
REQ-007 SHALL have Tx output 4*ND e1of4 rails, digit k on Tx[4k+3:4k]; Txe input 1 asynchronous enable from receiver (high = ready for data, low = data acknowledged).
REQ-008 SHALL have tx_count output 16 completed-handshake count; busy output 1 (FIFO non-empty or FSM not IDLE); timeout_err output 1 sticky error.

Function
REQ-009 SHALL synchronise Txe through SYNC_STAGES flops to txe_s; only txe_s is used internally.
REQ-010 SHALL buffer accepted tokens in a DEPTH-entry FIFO; in_ready = not full; a push on a full FIFO is impossible by construction, including a same-cycle pop.
REQ-011 SHALL encode digit k value v = token[2k+1:2k] as one-hot Tx[4k+v]; neutral = all rails 0.
REQ-012 SHALL drive Tx from registers only (no combinational path to Tx), so rails never glitch.
REQ-013 SHALL implement FSM IDLE, DATA, NEUTRAL.
REQ-014 IDLE -> DATA when FIFO non-empty and txe_s=1: same edge pops FIFO head and loads encoded rails to Tx.
REQ-015 IDLE with txe_s=0 SHALL hold Tx neutral and not pop, regardless of FIFO contents.
REQ-016 DATA -> NEUTRAL when txe_s=0: same edge clears Tx to neutral.
REQ-017 NEUTRAL -> IDLE when txe_s=1: same edge increments tx_count (wraps 0xFFFF->0x0000).
REQ-018 Minimum latency: token pushed at edge t with txe_s already 1 appears on Tx at edge t+1.
REQ-019 Back-to-back tokens SHALL take one IDLE cycle between NEUTRAL exit and next DATA entry.
REQ-020 SHALL count cycles spent in DATA or NEUTRAL, cleared on every state change; on reaching TIMEOUT set timeout_err=1, held until RESET; FSM keeps waiting, Tx unchanged.
REQ-021 SHALL accept pushes in any FSM state while not full.

Reset
REQ-022 RESET=1 SHALL asynchronously force: Tx=0, FSM=IDLE, FIFO empty (in_ready=1), tx_count=0, busy=0, timeout_err=0, synchroniser flops=0, timeout counter=0.
REQ-023 RESET asserted mid-handshake SHALL discard the in-flight and buffered tokens; no token is replayed after release.
REQ-024 First transition after RESET release SHALL require txe_s=1 observed through the full synchroniser.

Structure
REQ-025 Shared package e1of4_pkg SHALL hold the FSM state enum and the 2-bit-to-1of4 encode function.
REQ-026 FIFO SHALL be sub-module e1of4_token_fifo (params DW, DEPTH; push/pop/full/empty, async active-high reset); synchroniser and FSM stay in the top.

Verification (DW=4, DEPTH=4, SYNC_STAGES=2, TIMEOUT=15)
REQ-027 Reset: RESET=1 with Txe=1, token pending -> Tx=8'h00, in_ready=1, tx_count=0, timeout_err=0 immediately, without a CLK edge.
REQ-028 Single token: push 0xB, Txe=1 -> Tx=8'h48 next edge; drop Txe -> Tx=8'h00 three edges later; raise Txe -> tx_count=1 three edges later.
REQ-029 Full: Txe=0, push 0x1,0x2,0x3,0x4 -> in_ready=0, 5th offer 0x5 not accepted; raise Txe and cycle handshakes -> Tx shows 8'h12,8'h14,8'h18,8'h21 in order, tx_count=4.
REQ-030 Timeout: push 0x0, Txe held 1 after Tx=8'h11 -> timeout_err=1 at 15th DATA cycle, Tx stays 8'h11; later handshake completes, timeout_err remains 1.
REQ-031 Reset mid-DATA: Tx=8'h48, assert RESET -> Tx=8'h00 asynchronously; after release with Txe=1 and no pushes, Tx stays 8'h00, tx_count=0.
REQ-032 Stall: token pending, Txe=0 for 20 cycles -> Tx=8'h00, busy=1, no pop; Txe=1 -> data appears after the two synchroniser stages plus one edge.
